// File: rtl/pipe_field_pkg.sv
// Shared definitions for the pipe field renderer.
//   - 3-bit RGB colour constants for background, pipes and the player sprite
//   - scan state enumeration used by the renderer FSM
//   - col_height(): pulls one column height out of a packed height vector
// No ports; imported by pipe_field_renderer and field_scan_counter.
package pipe_field_pkg;

  localparam logic [2:0] BG_COL     = 3'b011;
  localparam logic [2:0] PIPE_COL   = 3'b110;
  localparam logic [2:0] PLAYER_COL = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    PLAYER,
    COLS,
    DONE
  } state_t;

  // Widest vector / height the helper accepts. Callers zero-extend their
  // vector to MAX_VEC_W and truncate the result back to their own height width.
  localparam int MAX_VEC_W = 2048;
  localparam int MAX_HGT_W = 16;

  // Column c lives at bits [(num_cols-c)*hgt_w-1 -: hgt_w], so column 0 is the
  // most significant field of the vector.
  function automatic logic [MAX_HGT_W-1:0] col_height(
    input logic [MAX_VEC_W-1:0] vec,
    input int                   c,
    input int                   num_cols,
    input int                   hgt_w
  );
    logic [MAX_HGT_W-1:0] mask;
    mask = MAX_HGT_W'((1 << hgt_w) - 1);
    return MAX_HGT_W'(vec >> ((num_cols - c - 1) * hgt_w)) & mask;
  endfunction

endpackage

// File: rtl/field_scan_counter.sv
// Nested scan counters for the field renderer.
// y_off counts fastest (0..FIELD_H-1), then sub (pixel within a strip or
// column), then col (pipe column index, only advanced outside the player phase).
// Ports:
//   clk, resetn     clock and synchronous active-low reset
//   clear           force all counters to zero (held while the renderer idles)
//   en              advance one pixel this cycle
//   player_phase    1: sub wraps at PLAYER_W-1 and col holds; 0: sub wraps at COL_W-1
//   y_off, sub, col current counter values
//   last_row, last_sub, last_col  counter-at-final-value flags
module field_scan_counter
  import pipe_field_pkg::*;
#(
  parameter int FIELD_H   = 80,
  parameter int COL_W     = 4,
  parameter int PLAYER_W  = 2,
  parameter int NUM_COLS  = 39,
  parameter int YO_W      = 7,
  parameter int SUB_W     = 3,
  parameter int COL_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 player_phase,
  output logic [YO_W-1:0]      y_off,
  output logic [SUB_W-1:0]     sub,
  output logic [COL_IDX_W-1:0] col,
  output logic                 last_row,
  output logic                 last_sub,
  output logic                 last_col
);

  assign last_row = (y_off == YO_W'(FIELD_H - 1));
  assign last_sub = player_phase ? (sub == SUB_W'(PLAYER_W - 1))
                                 : (sub == SUB_W'(COL_W - 1));
  assign last_col = (col == COL_IDX_W'(NUM_COLS - 1));

  // Every counter wraps back to zero on its own, so the phase change from the
  // player strip to the first pipe column needs no extra reload.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      y_off <= '0;
      sub   <= '0;
      col   <= '0;
    end else if (en) begin
      y_off <= last_row ? '0 : y_off + 1'b1;
      if (last_row) begin
        sub <= last_sub ? '0 : sub + 1'b1;
        if (last_sub && !player_phase)
          col <= last_col ? '0 : col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_field_renderer.sv
// Renders one frame of the play field (player strip, then NUM_COLS pipe
// columns) as a one-pixel-per-cycle stream for the vga_adapter write port.
// Ports:
//   clk, resetn        clock and synchronous active-low reset
//   frame_req          start a frame when idle (overrun pulse otherwise)
//   stall              freeze scan; plot forced low while asserted
//   player_h, col_h    live game state, snapshotted at frame start
//   x, y, colour, plot registered pixel write
//   busy               frame in progress
//   frame_done         one-cycle pulse after the last pixel
//   collide            collision result of the last completed frame
//   overrun            one-cycle pulse for a frame_req that was ignored
module pipe_field_renderer
  import pipe_field_pkg::*;
#(
  parameter int NUM_COLS = 39,
  parameter int COL_W    = 4,
  parameter int HGT_W    = 7,
  parameter int FIELD_H  = 80,
  parameter int Y_BASE   = 84,
  parameter int PLAYER_W = 2,
  parameter int PLAYER_H = 4,
  parameter int GAP      = 12,
  parameter int X_W      = 8,
  parameter int Y_W      = 7
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      frame_req,
  input  logic                      stall,
  input  logic [HGT_W-1:0]          player_h,
  input  logic [NUM_COLS*HGT_W-1:0] col_h,
  output logic [X_W-1:0]            x,
  output logic [Y_W-1:0]            y,
  output logic [2:0]                colour,
  output logic                      plot,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      collide,
  output logic                      overrun
);

  localparam int EXT_W     = HGT_W + 1;
  localparam int YO_W      = $clog2(FIELD_H + 1);
  localparam int SUB_MAX   = (COL_W > PLAYER_W) ? COL_W : PLAYER_W;
  localparam int SUB_W     = $clog2(SUB_MAX + 1);
  localparam int COL_IDX_W = $clog2(NUM_COLS + 1);

  state_t                    state;
  logic [NUM_COLS*HGT_W-1:0] snap;
  logic [HGT_W-1:0]          ph_snap;
  logic                      coll_snap;

  logic [YO_W-1:0]      y_off;
  logic [SUB_W-1:0]     sub;
  logic [COL_IDX_W-1:0] col;
  logic                 last_row, last_sub, last_col;
  logic                 scan_en;

  assign scan_en = !stall && (state == PLAYER || state == COLS);

  field_scan_counter #(
    .FIELD_H  (FIELD_H),
    .COL_W    (COL_W),
    .PLAYER_W (PLAYER_W),
    .NUM_COLS (NUM_COLS),
    .YO_W     (YO_W),
    .SUB_W    (SUB_W),
    .COL_IDX_W(COL_IDX_W)
  ) u_scan (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (state == IDLE),
    .en          (scan_en),
    .player_phase(state == PLAYER),
    .y_off       (y_off),
    .sub         (sub),
    .col         (col),
    .last_row    (last_row),
    .last_sub    (last_sub),
    .last_col    (last_col)
  );

  // Collision depends only on the snapshot, so it is evaluated from the live
  // inputs at the moment they are captured and simply held until DONE.
  logic [HGT_W-1:0] col0_h;
  logic [EXT_W-1:0] ph_in_ext, col0_ext;
  logic             coll_next;

  assign col0_h    = HGT_W'(col_height(MAX_VEC_W'(col_h), 0, NUM_COLS, HGT_W));
  assign ph_in_ext = EXT_W'(player_h);
  assign col0_ext  = EXT_W'(col0_h);
  assign coll_next = (player_h == '0)
                  || (ph_in_ext + EXT_W'(PLAYER_H) > EXT_W'(FIELD_H))
                  || ((col0_h != '0)
                      && ((ph_in_ext < col0_ext)
                          || (ph_in_ext + EXT_W'(PLAYER_H - 1) > col0_ext + EXT_W'(GAP))));

  // The snapshot shifts left one field per finished column, so the column
  // being drawn is always the top field; no wide index mux is needed.
  logic [HGT_W-1:0] cur_h;
  logic [EXT_W-1:0] y_ext, ph_ext, h_ext;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic [2:0]       pix_col;

  assign cur_h  = snap[NUM_COLS*HGT_W-1 -: HGT_W];
  assign y_ext  = EXT_W'(y_off);
  assign ph_ext = EXT_W'(ph_snap);
  assign h_ext  = EXT_W'(cur_h);
  assign pix_y  = Y_W'(Y_BASE - int'(y_off));

  always_comb begin
    pix_x   = X_W'(PLAYER_W + int'(col) * COL_W + int'(sub));
    pix_col = BG_COL;
    if (state == PLAYER) begin
      pix_x = X_W'(sub);
      if (y_ext >= ph_ext && y_ext <= ph_ext + EXT_W'(PLAYER_H - 1))
        pix_col = PLAYER_COL;
    end else if (cur_h != '0) begin
      if (y_ext < h_ext || y_ext > h_ext + EXT_W'(GAP))
        pix_col = PIPE_COL;
    end
  end

  // Stall freezes state and pixel registers but drops plot, so a pixel is
  // written exactly once no matter how the stall pattern falls.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      snap       <= '0;
      ph_snap    <= '0;
      coll_snap  <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= BG_COL;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      collide    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= frame_req && (state != IDLE);
      if (stall)
        plot <= 1'b0;
      case (state)
        IDLE: begin
          plot <= 1'b0;
          if (frame_req) begin
            snap      <= col_h;
            ph_snap   <= player_h;
            coll_snap <= coll_next;
            busy      <= 1'b1;
            state     <= PLAYER;
          end
        end
        PLAYER: begin
          if (!stall) begin
            x      <= pix_x;
            y      <= pix_y;
            colour <= pix_col;
            plot   <= 1'b1;
            if (last_row && last_sub)
              state <= COLS;
          end
        end
        COLS: begin
          if (!stall) begin
            x      <= pix_x;
            y      <= pix_y;
            colour <= pix_col;
            plot   <= 1'b1;
            if (last_row && last_sub) begin
              snap <= snap << HGT_W;
              if (last_col)
                state <= DONE;
            end
          end
        end
        DONE: begin
          if (!stall) begin
            plot       <= 1'b0;
            frame_done <= 1'b1;
            collide    <= coll_snap;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_field_renderer.sv
// Scoreboard bench for pipe_field_renderer: each frame request pushes the
// expected pixel stream, a negedge monitor pops and compares every plotted
// pixel, and the frame driver checks timing, collision and handshakes.
module tb_pipe_field_renderer;

  localparam int NUM_COLS  = 39;
  localparam int COL_W     = 4;
  localparam int HGT_W     = 7;
  localparam int FIELD_H   = 80;
  localparam int Y_BASE    = 84;
  localparam int PLAYER_W  = 2;
  localparam int PLAYER_H  = 4;
  localparam int GAP       = 12;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int VEC_W     = NUM_COLS * HGT_W;
  localparam int FRAME_PIX = PLAYER_W * FIELD_H + NUM_COLS * COL_W * FIELD_H;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             frame_req = 1'b0;
  logic             stall = 1'b0;
  logic [HGT_W-1:0] player_h = '0;
  logic [VEC_W-1:0] col_h = '0;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [2:0]       colour;
  logic             plot, busy, frame_done, collide, overrun;

  pipe_field_renderer #(
    .NUM_COLS(NUM_COLS), .COL_W(COL_W), .HGT_W(HGT_W), .FIELD_H(FIELD_H),
    .Y_BASE(Y_BASE), .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H), .GAP(GAP),
    .X_W(X_W), .Y_W(Y_W)
  ) dut (
    .clk(clk), .resetn(resetn), .frame_req(frame_req), .stall(stall),
    .player_h(player_h), .col_h(col_h), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .frame_done(frame_done), .collide(collide),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          edge_cnt = 0;
  int          pix_cnt = 0;
  int          last_plot_edge = 0;
  logic [17:0] exp_q[$];
  logic [17:0] pix_log[FRAME_PIX];
  logic [17:0] mon_px;
  logic [17:0] mon_exp;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Monitor: every plotted pixel must match the head of the expected queue.
  always @(negedge clk) begin
    if (resetn && plot) begin
      mon_px = {x, y, colour};
      if (pix_cnt < FRAME_PIX) pix_log[pix_cnt] = mon_px;
      pix_cnt++;
      last_plot_edge = edge_cnt;
      checkOutput("queue_nonempty", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        checkOutput("pixel", int'(mon_px), int'(mon_exp));
      end
    end
  end

  task automatic pushFrame(input int ph, input logic [VEC_W-1:0] cv);
    int h;
    logic [2:0] c3;
    for (int s = 0; s < PLAYER_W; s++)
      for (int yo = 0; yo < FIELD_H; yo++) begin
        c3 = (yo >= ph && yo <= ph + PLAYER_H - 1) ? 3'b100 : 3'b011;
        exp_q.push_back({8'(s), 7'(Y_BASE - yo), c3});
      end
    for (int c = 0; c < NUM_COLS; c++) begin
      h = int'(cv[(NUM_COLS - c) * HGT_W - 1 -: HGT_W]);
      for (int sb = 0; sb < COL_W; sb++)
        for (int yo = 0; yo < FIELD_H; yo++) begin
          c3 = (h != 0 && (yo < h || yo > h + GAP)) ? 3'b110 : 3'b011;
          exp_q.push_back({8'(PLAYER_W + c * COL_W + sb), 7'(Y_BASE - yo), c3});
        end
    end
  endtask

  function automatic logic expCollide(input int ph, input logic [VEC_W-1:0] cv);
    int h0;
    h0 = int'(cv[VEC_W - 1 -: HGT_W]);
    if (ph == 0 || ph + PLAYER_H > FIELD_H) return 1'b1;
    if (h0 != 0 && (ph < h0 || ph + PLAYER_H - 1 > h0 + GAP)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [VEC_W-1:0] randCols();
    logic [VEC_W-1:0] cv;
    cv = '0;
    for (int c = 0; c < NUM_COLS; c++)
      if ($urandom_range(0, 4) != 0)
        cv[(NUM_COLS - c) * HGT_W - 1 -: HGT_W] = HGT_W'($urandom_range(1, 70));
    return cv;
  endfunction

  // Drives one frame. stall_mode stalls every third cycle (and at the request
  // edge); overrun_at/reset_at inject a request or a reset at that scan cycle.
  task automatic applyStimulus(input int ph, input logic [VEC_W-1:0] cv,
                               input bit stall_mode, input int overrun_at,
                               input int reset_at);
    int   k, stall_cnt, e0;
    bit   done, aborted;
    logic exp_coll;
    @(posedge clk); #1;
    player_h  = HGT_W'(ph);
    col_h     = cv;
    frame_req = 1'b1;
    stall     = stall_mode;
    exp_q.delete();
    pushFrame(ph, cv);
    exp_coll = expCollide(ph, cv);
    pix_cnt  = 0;
    @(posedge clk); #1;
    e0        = edge_cnt;
    frame_req = 1'b0;
    checkOutput("busy_start", int'(busy), 1);
    player_h = HGT_W'($urandom);
    col_h    = randCols();
    stall_cnt = 0; done = 0; aborted = 0; k = 0;
    while (!done && !aborted && k < 20000) begin
      if (frame_done) done = 1;
      else if (k == reset_at) begin
        resetn = 1'b0;
        stall  = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_plot", int'(plot), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_collide", int'(collide), 0);
        exp_q.delete();
        resetn  = 1'b1;
        aborted = 1;
      end else begin
        if (overrun_at >= 0 && k == overrun_at) checkOutput("overrun_quiet", int'(overrun), 0);
        if (overrun_at >= 0 && k == overrun_at + 1) checkOutput("overrun_pulse", int'(overrun), 1);
        frame_req = (k == overrun_at);
        stall     = stall_mode && (k % 3 == 1);
        if (stall) stall_cnt++;
        @(posedge clk); #1;
        k++;
      end
    end
    stall     = 1'b0;
    frame_req = 1'b0;
    if (aborted) begin
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        checkOutput("abort_quiet", int'({frame_done, plot, busy}), 0);
      end
    end else begin
      checkOutput("done_seen", int'(done), 1);
      if (done) begin
        checkOutput("done_edge", edge_cnt - e0, FRAME_PIX + 1 + stall_cnt);
        checkOutput("collide", int'(collide), int'(exp_coll));
        checkOutput("busy_at_done", int'(busy), 0);
        checkOutput("pixel_count", pix_cnt, FRAME_PIX);
        checkOutput("queue_empty", exp_q.size(), 0);
        if (!stall_mode) checkOutput("done_after_last", edge_cnt - last_plot_edge, 1);
      end
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        checkOutput("post_quiet", int'({frame_done, plot, busy}), 0);
      end
    end
  endtask

  logic [VEC_W-1:0] cv_b;

  initial begin
    $display("[TB] starting pipe_field_renderer bench");
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_x", int'(x), 0);
    checkOutput("rst_y", int'(y), 0);
    checkOutput("rst_colour", int'(colour), 3);
    checkOutput("rst_flags", int'({plot, busy, frame_done, collide, overrun}), 0);
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      checkOutput("idle", int'({plot, busy, collide}), 0);
    end

    // Empty field, player mid-height
    applyStimulus(40, '0, 1'b0, -1, -1);
    checkOutput("a_first", int'(pix_log[0]),  int'({8'd0, 7'd84, 3'b011}));
    checkOutput("a_y44",   int'(pix_log[40]), int'({8'd0, 7'd44, 3'b100}));
    checkOutput("a_y41",   int'(pix_log[43]), int'({8'd0, 7'd41, 3'b100}));
    checkOutput("a_y40",   int'(pix_log[44]), int'({8'd0, 7'd40, 3'b011}));

    // Column 0 at height 30, player clear of both pipe edges, extra request
    cv_b = randCols();
    cv_b[VEC_W - 1 -: HGT_W] = 7'd30;
    applyStimulus(35, cv_b, 1'b0, 500, -1);
    checkOutput("b_yo29", int'(pix_log[189]), int'({8'd2, 7'd55, 3'b110}));
    checkOutput("b_yo30", int'(pix_log[190]), int'({8'd2, 7'd54, 3'b011}));
    checkOutput("b_yo42", int'(pix_log[202]), int'({8'd2, 7'd42, 3'b011}));
    checkOutput("b_yo43", int'(pix_log[203]), int'({8'd2, 7'd41, 3'b110}));
    checkOutput("b_x5",   int'(pix_log[443]), int'({8'd5, 7'd41, 3'b110}));

    // Player top above the gap, with periodic stall
    applyStimulus(40, cv_b, 1'b1, -1, -1);

    // Floor and ceiling collisions
    applyStimulus(0, '0, 1'b0, -1, -1);
    applyStimulus(77, '0, 1'b0, -1, -1);

    // Reset mid-frame
    applyStimulus(20, randCols(), 1'b0, -1, 6000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
